conv_requant_writer: RTL and testbench

- Downstream stage of the 2D convolution datapath.
- Accepts 32-bit signed accumulator results, one per strobe, adds a per-kernel bias, then rounds, shifts and saturates each result to 16-bit signed.
- Buffers the requantized pixels in a small FIFO and writes them sequentially into the 14-bit-addressed result memory through a port that may stall.
- Signals completion after one full output feature map.

---
 rtl/conv_requant_writer.sv | 194 +++++++++++++++++++
 tb/tb_conv_requant_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_requant_writer.sv
// conv_requant_writer: adds a bias to each convolution accumulator result,
// rounds, shifts and saturates it to 16-bit signed, buffers it in a small
// FIFO and writes one output feature map sequentially into result memory.
// Optional build macro QUANT_RELU_EN clamps negative results to zero.
//
// state | meaning
// IDLE  | waiting for start; stray acc_valid ignored
// RUN   | accepting samples until OUT_COUNT have been accepted
// DRAIN | inputs ignored; emptying pipeline and FIFO into memory
// DONE  | one-cycle done pulse, then back to IDLE
module conv_requant_writer #(
   parameter int IMG_WIDTH   = 48,
   parameter int KERNEL_SIZE = 3,
   parameter int OUT_COUNT   = (IMG_WIDTH - KERNEL_SIZE + 1) * (IMG_WIDTH - KERNEL_SIZE + 1),
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] base_result_addr,
   input  logic [15:0] bias,
   input  logic [4:0]  shift,
   input  logic        acc_valid,
   input  logic [31:0] acc_in,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [13:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        busy,
   output logic        done,
   output logic        overflow
);
   localparam int CNT_W = $clog2(OUT_COUNT + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [13:0]        base_q, base_d;
   logic [15:0]        bias_q, bias_d;
   logic [4:0]         shift_q, shift_d;
   logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic               ovf_q, ovf_d;
   logic               s1_valid_q, s1_valid_d;
   logic [32:0]        s1_sum_q, s1_sum_d;
   logic [15:0]        fifo_mem_q [FIFO_DEPTH];
   logic [15:0]        fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic               mem_we_q, mem_we_d;
   logic [13:0]        mem_addr_q, mem_addr_d;
   logic [15:0]        mem_data_q, mem_data_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic signed [33:0] sum34, rnd34, shifted;
   logic [15:0]        q_val;
   logic               pop, push, take, accept, drop;
   logic [OCC_W-1:0]   occ;

   // S2 arithmetic: round half up, arithmetic shift, saturate (optional ReLU)
   always_comb begin
      sum34   = $signed({s1_sum_q[32], s1_sum_q});
      rnd34   = '0;
      if (shift_q != 5'd0) rnd34 = 34'sd1 <<< (shift_q - 5'd1);
      shifted = (sum34 + rnd34) >>> shift_q;
      if (shifted > 34'sd32767)        q_val = 16'h7FFF;
      else if (shifted < -34'sd32768)  q_val = 16'h8000;
      else                             q_val = shifted[15:0];
`ifdef QUANT_RELU_EN
      if (q_val[15]) q_val = '0;
`endif
   end

   // Acceptance: occupancy seen by a new sample is the FIFO after this
   // cycle's pop plus whatever sits in S1, so the FIFO can never overrun.
   always_comb begin
      pop    = (fifo_cnt_q != '0) && mem_ready;
      push   = s1_valid_q && ((fifo_cnt_q != OCC_W'(FIFO_DEPTH)) || pop);
      occ    = fifo_cnt_q + OCC_W'(s1_valid_q) - OCC_W'(pop);
      take   = (state_q == RUN) && acc_valid && (acc_cnt_q < CNT_W'(OUT_COUNT));
      accept = take && (occ < OCC_W'(FIFO_DEPTH));
      drop   = take && !accept;
   end

   // Next-state, pipeline, FIFO and write-port logic
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      bias_d     = bias_q;
      shift_d    = shift_q;
      acc_cnt_d  = acc_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      ovf_d      = ovf_q;
      fifo_mem_d = fifo_mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fifo_cnt_d = fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      s1_valid_d = accept;
      s1_sum_d   = s1_sum_q;

      if (accept)
         s1_sum_d = {acc_in[31], acc_in} + {{17{bias_q[15]}}, bias_q};

      if (push) begin
         fifo_mem_d[wr_ptr_q] = q_val;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         mem_we_d   = 1'b1;
         mem_addr_d = base_q + 14'(wr_cnt_q);
         mem_data_d = fifo_mem_q[rd_ptr_q];
         wr_cnt_d   = wr_cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: if (start) begin
            base_d    = base_result_addr;
            bias_d    = bias;
            shift_d   = shift;
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
            ovf_d     = 1'b0;
            state_d   = RUN;
         end
         RUN: begin
            if (accept) acc_cnt_d = acc_cnt_q + CNT_W'(1);
            if (drop)   ovf_d     = 1'b1;
            if (acc_cnt_q == CNT_W'(OUT_COUNT)) state_d = DRAIN;
         end
         DRAIN: if ((wr_cnt_q == CNT_W'(OUT_COUNT)) && !s1_valid_q && (fifo_cnt_q == '0))
            state_d = DONE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         bias_q     <= '0;
         shift_q    <= '0;
         acc_cnt_q  <= '0;
         wr_cnt_q   <= '0;
         ovf_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         bias_q     <= bias_d;
         shift_q    <= shift_d;
         acc_cnt_q  <= acc_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         ovf_q      <= ovf_d;
         s1_valid_q <= s1_valid_d;
         s1_sum_q   <= s1_sum_d;
         fifo_mem_q <= fifo_mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_conv_requant_writer.sv
// Scoreboard bench for conv_requant_writer: directed stimulus pushes the
// hand-computed expected (address, data) of every write; a monitor pops and
// compares on each mem_we. Honors QUANT_RELU_EN for expected negatives.
module tb_conv_requant_writer;
   logic        clk = 1'b0;
   logic        rst, start, acc_valid, mem_ready;
   logic [13:0] base_result_addr;
   logic [15:0] bias;
   logic [4:0]  shift;
   logic [31:0] acc_in;
   logic        mem_we, busy, done, overflow;
   logic [13:0] mem_addr;
   logic [15:0] mem_data;

   typedef struct {int addr; int data;} exp_t;
   exp_t sbq[$];
   int checks = 0;
   int errors = 0;
   int wr_seen = 0;

   conv_requant_writer dut (
      .clk(clk), .rst(rst), .start(start), .base_result_addr(base_result_addr),
      .bias(bias), .shift(shift), .acc_valid(acc_valid), .acc_in(acc_in),
      .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_data(mem_data), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic int rq(int v);
`ifdef QUANT_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(int addr, int data);
      exp_t e;
      e.addr = addr;
      e.data = data;
      sbq.push_back(e);
   endtask

   task automatic do_start(int base, int b, int sh);
      start = 1'b1;
      base_result_addr = 14'(base);
      bias = 16'(b);
      shift = 5'(sh);
      cyc();
      start = 1'b0;
   endtask

   task automatic strobe(int v);
      acc_valid = 1'b1;
      acc_in = 32'(v);
      cyc();
      acc_valid = 1'b0;
   endtask

   task automatic do_reset();
      check("all_expected_written", sbq.size(), 0);
      sbq.delete();
      rst = 1'b1;
      acc_valid = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      check("no_write_after_reset", int'(mem_we), 0);
   endtask

   // Monitor: every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         wr_seen++;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                     mem_addr, $signed(mem_data));
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if (int'(mem_addr) != e.addr || int'($signed(mem_data)) != e.data) begin
               errors++;
               $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                        mem_addr, $signed(mem_data), e.addr, e.data);
            end
         end
      end
   end

   initial begin
      int n0, we_cnt, done_cnt, busy_at_done, busy_after;
      rst = 1'b1; start = 1'b0; acc_valid = 1'b0; mem_ready = 1'b1;
      base_result_addr = '0; bias = '0; shift = '0; acc_in = '0;
      cyc(); cyc();
      rst = 1'b0;
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_data", int'(mem_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_overflow", int'(overflow), 0);

      // Arithmetic and latency: (38+5+2)>>>2 = 11 at t+3
      do_start(100, 5, 2);
      check("busy_after_start", int'(busy), 1);
      expect_wr(100, 11);
      strobe(38);
      cyc();
      check("lat_t2_no_we", int'(mem_we), 0);
      cyc();
      check("lat_t3_we", int'(mem_we), 1);
      expect_wr(101, rq(-8));  strobe(-38);  // (-33+2)>>>2 = -8
      expect_wr(102, 11);      strobe(37);   // (42+2)>>>2 = 11
      expect_wr(103, 2);       strobe(1);    // (6+2)>>>2 = 2
      repeat (6) cyc();
      do_start(0, 0, 0);                     // ignored while RUN
      expect_wr(104, 11);      strobe(38);
      repeat (6) cyc();
      do_reset();

      // Negative bias, shift 4
      do_start(150, -16, 4);
      expect_wr(150, 62);      strobe(1000); // (984+8)>>>4 = 62
      expect_wr(151, 0);       strobe(8);    // (-8+8)>>>4 = 0
      expect_wr(152, rq(-2));  strobe(-24);  // (-40+8)>>>4 = -2
      repeat (6) cyc();
      do_reset();

      // Saturation, shift 0
      do_start(200, 0, 0);
      expect_wr(200, 32767);       strobe(32'h7FFFFFF0);
      expect_wr(201, rq(-32768));  strobe(-100000);
      expect_wr(202, 1234);        strobe(1234);
      expect_wr(203, rq(-5));      strobe(-5);
      repeat (6) cyc();
      do_reset();

      // Stall: 8 strobes with mem_ready low, only 4 fit
      do_start(300, 0, 0);
      mem_ready = 1'b0;
      n0 = wr_seen;
      for (int i = 0; i < 8; i++) begin
         acc_valid = 1'b1; acc_in = 32'(10 + i); cyc();
      end
      acc_valid = 1'b0;
      for (int i = 0; i < 4; i++) expect_wr(300 + i, 10 + i);
      repeat (3) cyc();
      check("stall_no_writes", wr_seen - n0, 0);
      check("stall_overflow", int'(overflow), 1);
      mem_ready = 1'b1;
      repeat (10) cyc();
      check("stall_release_writes", wr_seen - n0, 4);
      check("overflow_sticky", int'(overflow), 1);
      do_reset();

      // Full FIFO with simultaneous push and pop
      do_start(500, 0, 0);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         acc_valid = 1'b1; acc_in = 32'(20 + i); cyc();
      end
      acc_valid = 1'b0;
      cyc(); cyc();
      check("fill_no_overflow", int'(overflow), 0);
      for (int i = 0; i < 14; i++) expect_wr(500 + i, 20 + i);
      mem_ready = 1'b1;
      we_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         acc_valid = 1'b1; acc_in = 32'(24 + i); cyc();
         if (mem_we) we_cnt++;
      end
      acc_valid = 1'b0;
      check("pushpop_continuous_we", we_cnt, 10);
      repeat (10) cyc();
      check("pushpop_no_overflow", int'(overflow), 0);
      do_reset();

      // Reset mid-map leaves no stale data
      do_start(700, 0, 0);
      mem_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         acc_valid = 1'b1; acc_in = 32'(900 + i); cyc();
      end
      acc_valid = 1'b0;
      do_reset();
      check("busy_after_abort", int'(busy), 0);
      mem_ready = 1'b1;
      do_start(0, 0, 0);
      expect_wr(0, 7); strobe(7);
      expect_wr(1, 8); strobe(8);
      expect_wr(2, 9); strobe(9);
      repeat (6) cyc();
      do_reset();

      // Full map with address wrap
      do_start(16380, 0, 0);
      for (int i = 0; i < 2116; i++) begin
         expect_wr((16380 + i) % 16384, i);
         acc_valid = 1'b1; acc_in = 32'(i);
         if (i == 50) begin
            start = 1'b1; base_result_addr = 14'd0;
         end
         cyc();
         start = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         acc_valid = 1'b1; acc_in = 32'(-1); cyc();
      end
      acc_valid = 1'b0;
      done_cnt = 0; busy_at_done = 0; busy_after = 1;
      for (int i = 0; i < 60; i++) begin
         if (done) begin
            done_cnt++;
            busy_at_done = int'(busy);
            cyc();
            busy_after = int'(busy);
         end else begin
            cyc();
         end
      end
      check("map_done_pulses", done_cnt, 1);
      check("map_busy_at_done", busy_at_done, 1);
      check("map_busy_falls", busy_after, 0);
      check("map_no_overflow", int'(overflow), 0);
      check("map_all_written", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
